nway_access_logic: RTL

NWAY_ACCESS_LOGIC -- requirements
Module: nway_access_logic

---
 rtl/cpu_types_pkg.sv | 12 +
 rtl/nway_access_logic_lru_select.sv | 58 +++++
 rtl/nway_access_logic.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: the datapath word and the cache controller state encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2
  } cache_state_t;

endpackage

// File: rtl/nway_access_logic_lru_select.sv
// Per-set LRU bookkeeping: age update on hit/fill and victim choice (lowest invalid, else oldest).
module lru_select #(
  parameter  int WAYS = 2,
  localparam int AGEW = $clog2(WAYS)
) (
  input  logic [WAYS-1:0][AGEW-1:0] age_i,
  input  logic [WAYS-1:0]           valid_i,
  input  logic                      hit_en_i,
  input  logic [AGEW-1:0]           hit_way_i,
  input  logic                      fill_en_i,
  input  logic [AGEW-1:0]           fill_way_i,
  output logic [WAYS-1:0][AGEW-1:0] age_o,
  output logic [AGEW-1:0]           victim_o
);

  logic [AGEW-1:0] hit_age;
  logic [AGEW-1:0] max_age;
  logic            found_inv;

  // A freshly filled way is parked at the oldest age; the re-presented hit
  // that follows promotes it and ages everyone else, keeping a permutation.
  always_comb begin
    hit_age = age_i[hit_way_i];
    age_o   = age_i;
    if (hit_en_i) begin
      for (int w = 0; w < WAYS; w++) begin
        if (w[AGEW-1:0] == hit_way_i) begin
          age_o[w] = '0;
        end else if (age_i[w] < hit_age) begin
          age_o[w] = age_i[w] + AGEW'(1);
        end
      end
    end else if (fill_en_i) begin
      age_o[fill_way_i] = '1;
    end
  end

  always_comb begin
    found_inv = 1'b0;
    victim_o  = '0;
    max_age   = age_i[0];
    for (int w = 0; w < WAYS; w++) begin
      if (!valid_i[w] && !found_inv) begin
        found_inv = 1'b1;
        victim_o  = w[AGEW-1:0];
      end
    end
    if (!found_inv) begin
      for (int w = 1; w < WAYS; w++) begin
        if (age_i[w] > max_age) begin
          max_age  = age_i[w];
          victim_o = w[AGEW-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/nway_access_logic.sv
// N-way set-associative write-back data cache controller (IDLE / WB / FILL).
// Define ACCESS_LOGIC_STATS_EN to add saturating hit_count / miss_count outputs.
module nway_access_logic
  import cpu_types_pkg::*;
#(
  parameter int WAYS     = 2,
  parameter int SETS     = 8,
  parameter int BLKWORDS = 2
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  dmemREN,
  input  logic  dmemWEN,
  input  word_t dmemaddr,
  input  word_t dmemstore,
  output logic  dhit,
  output word_t dmemload,
  output logic  dREN,
  output logic  dWEN,
  output word_t daddr,
  output word_t dstore,
  input  logic  dwait,
  input  word_t dload
`ifdef ACCESS_LOGIC_STATS_EN
  ,
  output word_t hit_count,
  output word_t miss_count
`endif
);

  localparam int AGEW = $clog2(WAYS);
  localparam int OFFW = $clog2(BLKWORDS);
  localparam int IDXW = $clog2(SETS);
  localparam int TAGW = 30 - OFFW - IDXW;
  localparam logic [OFFW-1:0] LAST_WORD = OFFW'(BLKWORDS - 1);

  logic [TAGW-1:0] req_tag;
  logic [IDXW-1:0] req_idx;
  logic [OFFW-1:0] req_off;
  logic            addr_unused;
  logic            req;

  assign req_tag     = dmemaddr[31 -: TAGW];
  assign req_idx     = dmemaddr[2+OFFW +: IDXW];
  assign req_off     = dmemaddr[2 +: OFFW];
  assign addr_unused = ^dmemaddr[1:0];
  assign req         = dmemREN | dmemWEN;

  cache_state_t    state_q, state_d;
  logic [OFFW-1:0] word_q, word_d;
  logic [AGEW-1:0] victim_q, victim_d;
  logic [TAGW-1:0] fill_tag_q, fill_tag_d;
  logic [IDXW-1:0] fill_idx_q, fill_idx_d;

  logic [WAYS-1:0]           valid_q [SETS];
  logic [WAYS-1:0]           valid_d [SETS];
  logic [WAYS-1:0]           dirty_q [SETS];
  logic [WAYS-1:0]           dirty_d [SETS];
  logic [WAYS-1:0][AGEW-1:0] age_q   [SETS];
  logic [WAYS-1:0][AGEW-1:0] age_d   [SETS];
  logic [TAGW-1:0]           tag_q   [SETS][WAYS];
  logic [TAGW-1:0]           tag_d   [SETS][WAYS];
  word_t                     data_q  [SETS][WAYS][BLKWORDS];
  word_t                     data_d  [SETS][WAYS][BLKWORDS];

  logic                      hit_any;
  logic [AGEW-1:0]           hit_way;
  logic                      miss_idle;
  logic                      fill_done;
  logic [IDXW-1:0]           lru_idx;
  logic [WAYS-1:0][AGEW-1:0] lru_age;
  logic [AGEW-1:0]           lru_victim;

  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
        hit_any = 1'b1;
        hit_way = w[AGEW-1:0];
      end
    end
  end

  assign dhit      = (state_q == IDLE) && req && hit_any;
  assign miss_idle = (state_q == IDLE) && req && !hit_any;
  assign fill_done = (state_q == FILL) && !dwait && (word_q == LAST_WORD);
  assign lru_idx   = (state_q == IDLE) ? req_idx : fill_idx_q;

  lru_select #(.WAYS(WAYS)) u_lru (
    .age_i      (age_q[lru_idx]),
    .valid_i    (valid_q[lru_idx]),
    .hit_en_i   (dhit),
    .hit_way_i  (hit_way),
    .fill_en_i  (fill_done),
    .fill_way_i (victim_q),
    .age_o      (lru_age),
    .victim_o   (lru_victim)
  );

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    victim_d   = victim_q;
    fill_tag_d = fill_tag_q;
    fill_idx_d = fill_idx_q;
    valid_d    = valid_q;
    dirty_d    = dirty_q;
    age_d      = age_q;
    tag_d      = tag_q;
    data_d     = data_q;
    dREN       = 1'b0;
    dWEN       = 1'b0;
    daddr      = '0;
    dstore     = '0;
    dmemload   = dhit ? data_q[req_idx][hit_way][req_off] : '0;

    age_d[lru_idx] = lru_age;

    case (state_q)
      IDLE: begin
        if (dhit) begin
          if (dmemWEN) begin
            data_d[req_idx][hit_way][req_off] = dmemstore;
            dirty_d[req_idx][hit_way]         = 1'b1;
          end
        end else if (req) begin
          victim_d   = lru_victim;
          fill_tag_d = req_tag;
          fill_idx_d = req_idx;
          word_d     = '0;
          state_d    = (valid_q[req_idx][lru_victim] && dirty_q[req_idx][lru_victim]) ? WB : FILL;
        end
      end
      WB: begin
        dWEN   = 1'b1;
        daddr  = {tag_q[fill_idx_q][victim_q], fill_idx_q, word_q, 2'b00};
        dstore = data_q[fill_idx_q][victim_q][word_q];
        if (!dwait) begin
          word_d = word_q + OFFW'(1);
          if (word_q == LAST_WORD) begin
            dirty_d[fill_idx_q][victim_q] = 1'b0;
            word_d  = '0;
            state_d = FILL;
          end
        end
      end
      FILL: begin
        dREN  = 1'b1;
        daddr = {fill_tag_q, fill_idx_q, word_q, 2'b00};
        if (!dwait) begin
          data_d[fill_idx_q][victim_q][word_q] = dload;
          word_d = word_q + OFFW'(1);
          if (word_q == LAST_WORD) begin
            valid_d[fill_idx_q][victim_q] = 1'b1;
            dirty_d[fill_idx_q][victim_q] = 1'b0;
            tag_d[fill_idx_q][victim_q]   = fill_tag_q;
            word_d  = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      word_q     <= '0;
      victim_q   <= '0;
      fill_tag_q <= '0;
      fill_idx_q <= '0;
      valid_q    <= '{default: '0};
      dirty_q    <= '{default: '0};
      age_q      <= '{default: '0};
      tag_q      <= '{default: '0};
      data_q     <= '{default: '0};
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      victim_q   <= victim_d;
      fill_tag_q <= fill_tag_d;
      fill_idx_q <= fill_idx_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      age_q      <= age_d;
      tag_q      <= tag_d;
      data_q     <= data_d;
    end
  end

`ifdef ACCESS_LOGIC_STATS_EN
  word_t hit_cnt_q, hit_cnt_d;
  word_t miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (dhit && (hit_cnt_q != '1)) hit_cnt_d = hit_cnt_q + 32'd1;
    if (miss_idle && (miss_cnt_q != '1)) miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  logic miss_unused;
  assign miss_unused = miss_idle;
`endif

endmodule
